// File: rtl/spart_io_pkg.sv
// spart_io_pkg: SPART address map, status bit positions and initiator FSM states
package spart_io_pkg;
  localparam logic [27:0] DATA_ADDR = 28'h800_0000;
  localparam logic [27:0] STATUS_ADDR = 28'h800_0001;
  localparam int RDA_BIT = 0;
  localparam int TBR_BIT = 1;
  typedef enum logic [2:0] {IDLE, POLL, DECIDE, READ_RX, WRITE_TX, REST} state_t;
endpackage

// File: rtl/spart_io_initiator_if.sv
// spart_io_initiator_if: SPART cache-port handshake (valid/rw/addr/wr_data out, ready/rd_data back)
interface spart_io_initiator_if #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 32
);
  logic io_valid_data;
  logic io_rw_data;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] io_wr_data;
  logic io_ready_data;
  logic [DATA_W-1:0] io_rd_data;
  modport master (
    output io_valid_data, io_rw_data, mem_addr, io_wr_data,
    input io_ready_data, io_rd_data
  );
  modport slave (
    input io_valid_data, io_rw_data, mem_addr, io_wr_data,
    output io_ready_data, io_rd_data
  );
endinterface

// File: rtl/byte_fifo.sv
// byte_fifo: DEPTH-entry byte FIFO (push/din, pop/dout head, registered full/empty; rst async active-low)
module byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] cnt, cnt_nx;
  logic do_push, do_pop;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign cnt_nx = cnt + CW'(do_push) - CW'(do_pop);
  assign dout = mem[rp];
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      full <= 1'b0;
      empty <= 1'b1;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wp] <= din;
        wp <= wp + AW'(1);
      end
      if (do_pop) rp <= rp + AW'(1);
      cnt <= cnt_nx;
      full <= cnt_nx == CW'(DEPTH);
      empty <= cnt_nx == '0;
    end
  end
endmodule

// File: rtl/spart_io_initiator.sv
// spart_io_initiator: polls SPART status, drains RX bytes to rx FIFO, feeds tx FIFO bytes out (bus via master modport; tx_*/rx_* byte client; timeout_err pulse)
module spart_io_initiator
  import spart_io_pkg::*;
#(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int POLL_GAP = 4,
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  spart_io_initiator_if.master bus,
  input  logic [7:0] tx_byte,
  input  logic tx_push,
  output logic tx_full,
  output logic [7:0] rx_byte,
  input  logic rx_pop,
  output logic rx_empty,
  output logic timeout_err
);
  localparam int GW = $clog2(POLL_GAP + 1);
  localparam int WW = $clog2(TIMEOUT + 1);
  state_t state;
  logic [GW-1:0] gap;
  logic [WW-1:0] wcnt;
  logic rda, tbr;
  logic rx_full, tx_empty, rx_push, tx_pop;
  logic [7:0] tx_head;
  logic unused_rd;
  assign unused_rd = ^bus.io_rd_data[DATA_W-1:8];
  assign rx_push = state == READ_RX && bus.io_ready_data;
  assign tx_pop = state == WRITE_TX && bus.io_ready_data;
  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx (
    .clk(clk), .rst(rst), .push(tx_push), .din(tx_byte), .pop(tx_pop),
    .dout(tx_head), .full(tx_full), .empty(tx_empty)
  );
  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx (
    .clk(clk), .rst(rst), .push(rx_push), .din(bus.io_rd_data[7:0]), .pop(rx_pop),
    .dout(rx_byte), .full(rx_full), .empty(rx_empty)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      gap <= '0;
      wcnt <= '0;
      rda <= 1'b0;
      tbr <= 1'b0;
      timeout_err <= 1'b0;
      bus.io_valid_data <= 1'b0;
      bus.io_rw_data <= 1'b0;
      bus.mem_addr <= '0;
      bus.io_wr_data <= '0;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (gap == GW'(POLL_GAP - 1)) begin
            state <= POLL;
            gap <= '0;
            wcnt <= '0;
            bus.io_valid_data <= 1'b1;
            bus.io_rw_data <= 1'b0;
            bus.mem_addr <= ADDR_W'(STATUS_ADDR);
          end else gap <= gap + GW'(1);
        end
        POLL, READ_RX, WRITE_TX: begin
          if (bus.io_ready_data) begin
            bus.io_valid_data <= 1'b0;
            state <= state == POLL ? DECIDE : REST;
            if (state == POLL) begin
              rda <= bus.io_rd_data[RDA_BIT];
              tbr <= bus.io_rd_data[TBR_BIT];
            end
          end else if (wcnt == WW'(TIMEOUT - 1)) begin
            bus.io_valid_data <= 1'b0;
            timeout_err <= 1'b1;
            state <= IDLE;
          end else wcnt <= wcnt + WW'(1);
        end
        DECIDE: begin
          wcnt <= '0;
          if (rda && !rx_full) begin
            state <= READ_RX;
            bus.io_valid_data <= 1'b1;
            bus.io_rw_data <= 1'b0;
            bus.mem_addr <= ADDR_W'(DATA_ADDR);
          end else if (tbr && !tx_empty) begin
            state <= WRITE_TX;
            bus.io_valid_data <= 1'b1;
            bus.io_rw_data <= 1'b1;
            bus.mem_addr <= ADDR_W'(DATA_ADDR);
            bus.io_wr_data <= {{(DATA_W - 8){1'b0}}, tx_head};
          end else state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spart_io_initiator.sv
// tb_spart_io_initiator: directed + randomized rounds against a queue-based model of the byte channel
module tb_spart_io_initiator;
  localparam int D = 4;
  localparam int PG = 4;
  localparam int TO = 255;
  localparam int LIM = 2 * PG + 20;
  localparam logic [27:0] A_DATA = 28'h800_0000;
  localparam logic [27:0] A_STAT = 28'h800_0001;
  logic clk, rst;
  logic [7:0] tx_byte, rx_byte;
  logic tx_push, tx_full, rx_pop, rx_empty, timeout_err;
  int cmp, errs, n;
  logic [7:0] rxq[$];
  logic [7:0] txq[$];
  spart_io_initiator_if #(.ADDR_W(28), .DATA_W(32)) bus ();
  spart_io_initiator #(
    .ADDR_W(28), .DATA_W(32), .FIFO_DEPTH(D), .POLL_GAP(PG), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .tx_byte(tx_byte), .tx_push(tx_push),
    .tx_full(tx_full), .rx_byte(rx_byte), .rx_pop(rx_pop), .rx_empty(rx_empty),
    .timeout_err(timeout_err)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    cmp++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic check_flags(input string tag);
    chk({tag, "_rx_empty"}, rx_empty, rxq.size() == 0);
    chk({tag, "_tx_full"}, tx_full, txq.size() == D);
    if (rxq.size() > 0) chk({tag, "_rx_byte"}, rx_byte, rxq[0]);
  endtask
  task automatic wait_valid(input bit push, input logic [7:0] pb, input bit pop, input bit noise, output int cnt);
    tx_push = push;
    tx_byte = pb;
    rx_pop = pop;
    if (noise) begin
      bus.io_ready_data = 1'b1;
      bus.io_rd_data = $urandom;
    end
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
      tx_push = 1'b0;
      rx_pop = 1'b0;
      bus.io_ready_data = 1'b0;
    end while (bus.io_valid_data !== 1'b1 && cnt < LIM);
  endtask
  task automatic serve(input string tag, input logic [27:0] a, input bit rw, input logic [31:0] wd, input logic [31:0] rd, input int lat);
    for (int k = 1; k <= lat; k++) begin
      chk(tag, {bus.io_valid_data, bus.io_rw_data, bus.mem_addr}, {1'b1, rw, a});
      if (rw) chk({tag, "_wd"}, bus.io_wr_data, wd);
      if (k == lat) begin
        bus.io_ready_data = 1'b1;
        bus.io_rd_data = rd;
      end
      @(negedge clk);
    end
    bus.io_ready_data = 1'b0;
    bus.io_rd_data = $urandom;
    chk({tag, "_drop"}, bus.io_valid_data, 1'b0);
  endtask
  task automatic round(input logic [31:0] st, input logic [31:0] d, input int lat, input bit push, input logic [7:0] pb, input bit pop, input bit noise);
    int g;
    serve("poll", A_STAT, 1'b0, 32'h0, st, lat);
    if (st[0] && rxq.size() < D) begin
      wait_valid(0, 8'h0, 0, 0, g);
      chk("gap_decide", g, 1);
      serve("rd", A_DATA, 1'b0, 32'h0, d, lat);
      rxq.push_back(d[7:0]);
    end else if (st[1] && txq.size() > 0) begin
      wait_valid(0, 8'h0, 0, 0, g);
      chk("gap_decide", g, 1);
      serve("wr", A_DATA, 1'b1, {24'd0, txq[0]}, d, lat);
      void'(txq.pop_front());
    end
    wait_valid(push, pb, pop, noise, g);
    chk("gap_idle", g, 1 + PG);
    if (push && txq.size() < D) txq.push_back(pb);
    if (pop && rxq.size() > 0) void'(rxq.pop_front());
    check_flags("round");
  endtask
  task automatic tmo(input string tag, input logic [27:0] a);
    int c;
    chk({tag, "_addr"}, bus.mem_addr, a);
    c = 0;
    while (bus.io_valid_data === 1'b1 && c < TO + 4) begin
      c++;
      @(negedge clk);
    end
    chk({tag, "_len"}, c, TO);
    chk({tag, "_err"}, timeout_err, 1'b1);
    @(negedge clk);
    chk({tag, "_pulse"}, timeout_err, 1'b0);
    wait_valid(0, 8'h0, 0, 0, c);
    chk({tag, "_gap"}, c, PG - 1);
    check_flags(tag);
  endtask
  initial begin
    cmp = 0;
    errs = 0;
    rst = 1'b0;
    tx_byte = 8'h0;
    tx_push = 1'b0;
    rx_pop = 1'b0;
    bus.io_ready_data = 1'b0;
    bus.io_rd_data = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_valid", bus.io_valid_data, 1'b0);
    chk("rst_rw", bus.io_rw_data, 1'b0);
    chk("rst_addr", bus.mem_addr, 28'h0);
    chk("rst_wd", bus.io_wr_data, 32'h0);
    chk("rst_err", timeout_err, 1'b0);
    chk("rst_tx_full", tx_full, 1'b0);
    chk("rst_rx_empty", rx_empty, 1'b1);
    chk("rst_rx_byte", rx_byte, 8'h0);
    rst = 1'b1;
    wait_valid(0, 8'h0, 0, 0, n);
    chk("first_poll", n, PG);
    round(32'h1, 32'h0000_0041, 2, 1, 8'h5A, 0, 0);
    chk("rx_41", rx_byte, 8'h41);
    round(32'h2, $urandom, 3, 0, 8'h0, 0, 0);
    round(32'h0, $urandom, 1, 1, 8'hC3, 0, 0);
    round(32'h3, 32'h0000_0077, 2, 0, 8'h0, 0, 0);
    round(32'h2, $urandom, 2, 0, 8'h0, 0, 0);
    tmo("tmo_poll", A_STAT);
    serve("poll", A_STAT, 1'b0, 32'h0, 32'h1, 2);
    wait_valid(0, 8'h0, 0, 0, n);
    chk("gap_decide", n, 1);
    tmo("tmo_rd", A_DATA);
    while (rxq.size() < D) round(32'h1, $urandom, 1, 1, 8'($urandom), 0, 0);
    round(32'h1, $urandom, 2, 1, 8'($urandom), 0, 0);
    while (txq.size() < D) round(32'h0, $urandom, 1, 1, 8'($urandom), 0, 0);
    round(32'h0, $urandom, 1, 1, 8'hEE, 0, 0);
    round(32'h3, $urandom, 2, 0, 8'h0, 0, 0);
    while (rxq.size() > 0) round(32'h0, $urandom, 1, 0, 8'h0, 1, 0);
    round(32'h0, $urandom, 1, 0, 8'h0, 1, 1);
    for (int i = 0; i < 60; i++)
      round($urandom, $urandom, $urandom_range(1, 5), 1'($urandom_range(0, 1)), 8'($urandom),
            $urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)));
    #2 rst = 1'b0;
    #1 chk("midrst_valid", bus.io_valid_data, 1'b0);
    chk("midrst_rx_empty", rx_empty, 1'b1);
    chk("midrst_tx_full", tx_full, 1'b0);
    rxq.delete();
    txq.delete();
    @(negedge clk);
    rst = 1'b1;
    wait_valid(0, 8'h0, 0, 0, n);
    chk("poll_after_rst", n, PG);
    round(32'h1, 32'h0000_00A5, 1, 0, 8'h0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end
endmodule

// File: doc/spart_io_initiator.md
# spart_io_initiator

Bus-side initiator for the SPART memory-mapped I/O interface: the block that drives the valid/rw/address/write-data handshake into the SPART cache-port responder and consumes its ready/read-data. It polls the SPART status word, drains received bytes into a local RX FIFO, and feeds bytes from a local TX FIFO to the transmit data register. It sits between a byte-stream client and the SPART top level, in place of the CPU/cache path when a standalone console channel is needed.

## Interface
Parameters:
- ADDR_W, 28, width of mem_addr
- DATA_W, 32, width of io_rd_data / io_wr_data
- FIFO_DEPTH, 4, entries per byte FIFO (power of two, ≥2)
- POLL_GAP, 4, idle cycles between poll rounds (≥1)
- TIMEOUT, 255, cycles an access may wait for ready before abort (≥3)

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- io_valid_data  output  1  access request
- io_rw_data  output  1  1 = write, 0 = read
- mem_addr  output  ADDR_W  access address
- io_wr_data  output  DATA_W  write data
- io_ready_data  input  1  access complete (responder)
- io_rd_data  input  DATA_W  read data, valid with io_ready_data
- tx_byte  input  8  byte to send
- tx_push  input  1  enqueue tx_byte
- tx_full  output  1  TX FIFO full
- rx_byte  output  8  head of RX FIFO
- rx_pop  input  1  dequeue rx_byte
- rx_empty  output  1  RX FIFO empty
- timeout_err  output  1  one-cycle pulse on access abort

## Operation
- Address map: DATA = 28'h800_0000, STATUS = 28'h800_0001. STATUS bit 0 = RDA (rx byte available), bit 1 = TBR (transmit buffer ready); other bits ignored.
- FSM states: IDLE, POLL, DECIDE, READ_RX, WRITE_TX, REST.
- IDLE: gap counter counts POLL_GAP cycles, then → POLL.
- POLL: read STATUS; on ready latch bits → DECIDE.
- DECIDE (one cycle, valid low): RDA && RX not full → READ_RX; else TBR && TX not empty → WRITE_TX; else → IDLE.
- READ_RX: read DATA; on ready push io_rd_data[7:0] into RX FIFO → REST.
- WRITE_TX: write DATA with io_wr_data = {24'd0, TX head}; on ready pop TX FIFO → REST.
- REST: one cycle valid low → IDLE (gap counter reloaded).
- RX service has priority over TX within a round; at most one data access per round.
- Timeout: wait counter starts at request assertion; reaching TIMEOUT without ready → drop valid, pulse timeout_err, → IDLE. No FIFO push/pop on an aborted access.
- FIFOs: push when full ignored; pop when empty ignored; simultaneous push+pop on non-empty, non-full FIFO keeps occupancy; push+pop on empty RX FIFO pushes only; rx_byte undefined-but-stable (hold last) when empty.

## Timing
- Reset (rst low, asynchronous): io_valid_data=0, io_rw_data=0, mem_addr=0, io_wr_data=0, timeout_err=0, tx_full=0, rx_empty=1, rx_byte=0, FSM=IDLE, FIFOs empty, counters 0. Reset mid-access drops valid immediately; queued bytes are lost.
- Request outputs registered; valid, rw, mem_addr, io_wr_data held constant from assertion until the cycle ready is sampled high.
- Valid deasserted the cycle after ready is sampled and stays low ≥1 cycle before the next request (responder's handshake counter must clear between accesses).
- io_rd_data sampled only in the cycle io_ready_data=1 with valid=1; ready while valid low is ignored.
- Responder minimum: ready no earlier than 2nd cycle of valid; block tolerates ready on any cycle ≥1.
- tx_full/rx_empty registered, updated the cycle after push/pop.
- Round with RDA: POLL ≥2 + DECIDE 1 + READ_RX ≥2 + REST 1 cycles, then POLL_GAP idle.

## Structure
- Package spart_io_pkg: DATA/STATUS address constants, RDA/TBR bit indices, FSM state enum.
- Sub-module byte_fifo (synchronous, parameter DEPTH, registered full/empty), instantiated twice (TX, RX).

## Test plan
- Reset with rst low: all outputs at reset values; after release, first POLL request (addr 800_0001, rw=0) after exactly POLL_GAP idle cycles.
- Status reads 32'h1, DATA reads 32'h0000_0041, ready on 2nd valid cycle → rx_empty falls, rx_byte=8'h41, valid low one cycle between accesses.
- Push 8'h5A, status 32'h2 → write to 800_0000 with io_wr_data=32'h0000_005A, held until ready; TX FIFO empty after.
- Status 32'h3 with RX non-full and TX non-empty → READ_RX issued first, WRITE_TX in next round.
- ready never asserted → valid dropped after TIMEOUT cycles, timeout_err single-cycle pulse, no FIFO change, next poll follows.
- Fill RX (FIFO_DEPTH bytes), status 32'h1 → no DATA read; push on full TX and pop on empty RX ignored.
